// File: rtl/imem_loader.sv
// imem_loader: streams a little-endian byte image into instruction memory,
// one 32-bit word per write, holding the CPU until the EXIT word arrives.
// Optional feature macro: CHECKSUM_EN (adds one trailing checksum byte after EXIT).
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err
);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CKSUM = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd4
  } state_t;
`endif

  localparam logic [31:0]       EXIT_WORD = 32'hFFFF_FFFF;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

`ifdef CHECKSUM_EN
  // Modulo-256 byte accumulation used by the image checksum.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction
`endif

  state_t      state_r;
  logic [1:0]  byte_idx_r;
`ifdef CHECKSUM_EN
  logic [7:0]  sum_r;
`endif

  logic        byte_fire_s;
  logic        is_exit_s;
  logic        is_last_s;
  logic [31:0] wdata_next_s;

  assign byte_fire_s = rx_valid & rx_ready;
  assign is_exit_s   = (imem_wdata == EXIT_WORD);
  assign is_last_s   = (imem_addr == LAST_ADDR);

  // Merge the incoming byte into its little-endian lane of the word being built.
  always_comb begin
    wdata_next_s = imem_wdata;
    case (byte_idx_r)
      2'd0:    wdata_next_s[7:0]   = rx_data;
      2'd1:    wdata_next_s[15:8]  = rx_data;
      2'd2:    wdata_next_s[23:16] = rx_data;
      2'd3:    wdata_next_s[31:24] = rx_data;
      default: wdata_next_s        = imem_wdata;
    endcase
  end

  // Loader FSM; every output is registered and updated on state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      byte_idx_r <= 2'd0;
`ifdef CHECKSUM_EN
      sum_r      <= 8'd0;
`endif
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      err        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r    <= ST_LOAD;
            byte_idx_r <= 2'd0;
`ifdef CHECKSUM_EN
            sum_r      <= 8'd0;
`endif
            imem_addr  <= '0;
            word_count <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            rx_ready   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (byte_fire_s) begin
            imem_wdata <= wdata_next_s;
            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef CHECKSUM_EN
            sum_r      <= sum8(sum_r, rx_data);
`endif
            if (byte_idx_r == 2'd3) begin
              // Word complete: stop accepting and strobe the write next cycle.
              rx_ready <= 1'b0;
              imem_we  <= 1'b1;
              state_r  <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          imem_we    <= 1'b0;
          word_count <= word_count + COUNT_ONE;
          // The address saturates at the top of memory instead of wrapping.
          if (!is_last_s) begin
            imem_addr <= imem_addr + ADDR_ONE;
          end
          if (is_exit_s) begin
`ifdef CHECKSUM_EN
            state_r  <= ST_CKSUM;
            rx_ready <= 1'b1;
`else
            state_r  <= ST_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
`endif
          end else if (is_last_s) begin
            // Memory full without EXIT: overflow, release the CPU anyway.
            state_r  <= ST_DONE;
            err      <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            state_r  <= ST_LOAD;
            rx_ready <= 1'b1;
          end
        end
`ifdef CHECKSUM_EN
        ST_CKSUM: begin
          if (byte_fire_s) begin
            err      <= (sum8(sum_r, rx_data) != 8'd0);
            rx_ready <= 1'b0;
            state_r  <= ST_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end
        end
`endif
        default: begin
          state_r  <= ST_IDLE;
          rx_ready <= 1'b0;
          imem_we  <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (small DEPTH=4 instance so overflow is
// reachable). Expected writes come from a word-level model of the image rules.
module tb_imem_loader;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam logic [31:0] EXIT_WORD = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [31:0] img[$];
  logic [33:0] wr_q[$];
  logic [33:0] exp_q[$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .word_count(word_count), .err(err)
  );

  always #5 clk = ~clk;

  // Record every memory write seen on the write port.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit with_valid, input logic [7:0] b);
    start = 1'b1;
    rx_valid = with_valid;
    rx_data = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int bubble_max);
    int n;
    repeat ($urandom_range(bubble_max, 0)) begin
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Load img[] and compare all writes and final status with the model.
  task automatic run_image(input int bubble_max, input logic [7:0] cks_off, input bit start_valid);
    int n_wr;
    bit exit_hit;
    bit exp_err;
    logic [7:0] sum;
    logic [7:0] cks;
    exp_q.delete();
    wr_q.delete();
    exit_hit = 1'b0;
    exp_err = 1'b0;
    sum = 8'd0;
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({2'(i), img[i]});
      for (int k = 0; k < 4; k++) sum = sum + img[i][8*k +: 8];
      if (img[i] == EXIT_WORD) begin exit_hit = 1'b1; break; end
      if (i == DEPTH - 1) begin exp_err = 1'b1; break; end
    end
    n_wr = exp_q.size();
    cks = 8'(8'd0 - sum) + cks_off;
`ifdef CHECKSUM_EN
    if (exit_hit) exp_err = ((sum + cks) != 8'd0);
`endif
    pulse_start(start_valid, img[0][7:0]);
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
    for (int i = 0; i < n_wr; i++)
      for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8], bubble_max);
`ifdef CHECKSUM_EN
    if (exit_hit) send_byte(cks, bubble_max);
`endif
    for (int n = 0; n < 20 && done !== 1'b1; n++) @(negedge clk);
    check("done", 64'(done), 64'd1);
    // Offer more bytes: a finished loader must neither accept nor write them.
    rx_valid = 1'b1;
    rx_data = 8'h13;
    repeat (6) begin
      @(negedge clk);
      check("rx_ready_in_done", 64'(rx_ready), 64'd0);
    end
    rx_valid = 1'b0;
    check("write_count", 64'(wr_q.size()), 64'(n_wr));
    for (int i = 0; i < n_wr && i < wr_q.size(); i++) check("write_addr_data", 64'(wr_q[i]), 64'(exp_q[i]));
    check("word_count", 64'(word_count), 64'(n_wr));
    check("err", 64'(err), 64'(exp_err));
    check("cpu_hold_released", 64'(cpu_hold), 64'd0);
    check("busy_done", 64'(busy), 64'd0);
  endtask

  task automatic load_test2_image();
    img.delete();
    img.push_back(32'h0007_B183);
    img.push_back(EXIT_WORD);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Test 1: idle without start, random traffic on rx must be ignored.
    for (int i = 0; i < 12; i++) begin
      rx_valid = 1'($urandom);
      rx_data = 8'($urandom);
      @(negedge clk);
      check("idle_hold", {59'd0, cpu_hold, rx_ready, imem_we, done, err}, 64'h10);
    end
    rx_valid = 1'b0;

    // Test 2: reference image, back-to-back, start coincident with first byte.
    load_test2_image();
    run_image(0, 8'd0, 1'b1);
    check("t2_word0", 64'(wr_q.size() > 0 ? wr_q[0] : 34'd0), 64'({2'd0, 32'h0007_B183}));

    // Test 3: same image with random bubbles.
    for (int r = 0; r < 3; r++) run_image(3, 8'd0, 1'b0);

`ifdef CHECKSUM_EN
    // Test 6: wrong checksum byte (C8) must flag err.
    run_image(1, 8'hFF, 1'b0);
`endif

    // Test 4: overflow with four NOP words and no EXIT.
    img.delete();
    repeat (4) img.push_back(32'h0000_0013);
    run_image(1, 8'd0, 1'b0);

    // Test 5: reset after two bytes discards the partial word.
    load_test2_image();
    wr_q.delete();
    pulse_start(1'b0, 8'd0);
    send_byte(8'h83, 0);
    send_byte(8'hB1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_state", {59'd0, cpu_hold, rx_ready, imem_we, busy, done}, 64'h10);
    check("midrst_count", 64'(word_count), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_write", 64'(wr_q.size()), 64'd0);
    check("midrst_hold", 64'(cpu_hold), 64'd1);
    run_image(0, 8'd0, 1'b0);

    // Random images: EXIT may appear anywhere or not at all (overflow).
    for (int r = 0; r < 10; r++) begin
      img.delete();
      for (int i = 0; i < 6; i++) img.push_back($urandom);
      if ($urandom_range(2, 0) != 0) img[$urandom_range(5, 0)] = EXIT_WORD;
      run_image($urandom_range(3, 0), ($urandom_range(1, 0) != 0) ? 8'd0 : 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
